// File: rtl/pellet_pkg.sv
// Shared constants and FSM encoding for the pellet eater.
// Grid is 32x32 tiles, addressed as {row, column}.
package pellet_pkg;

    localparam int GRID_BITS      = 5;
    localparam int CELLS          = 1024;
    localparam int ADDR_W         = 2 * GRID_BITS;
    localparam int CNT_W          = ADDR_W + 1;
    localparam int DEFAULT_POINTS = 10;

    typedef enum logic [2:0] {
        SCAN,
        IDLE,
        READ,
        CHECK,
        CLEAR
    } state_t;

endpackage

// File: rtl/pellet_eater_score.sv
// Saturating score accumulator: adds amount on inc, clamps at all-ones.
// Reset is synchronous, active-high.
module score_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic [W-1:0] amount,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_value} + {1'b0, amount};
    assign value = r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_sum[W] ? '1 : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/pellet_eater.sv
// Pellet eater: scans the external pellet store after reset, then serves
// eat requests one at a time against it, keeping score and pellets left.
module pellet_eater
    import pellet_pkg::*;
#(
    parameter int POINTS  = DEFAULT_POINTS,
    parameter int SCORE_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tile_valid,
    input  logic [GRID_BITS-1:0] tile_x,
    input  logic [GRID_BITS-1:0] tile_y,
    output logic                 tile_ready,
    output logic [GRID_BITS-1:0] xpos_b,
    output logic [GRID_BITS-1:0] ypos_b,
    output logic                 clear_b,
    input  logic                 out_b,
    output logic                 eaten,
    output logic [SCORE_W-1:0]   score,
    output logic [CNT_W-1:0]     remaining,
    output logic                 level_clear
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_scan;
    logic [CNT_W-1:0]     w_scan_inc;
    logic [GRID_BITS-1:0] r_x;
    logic [GRID_BITS-1:0] r_y;
    logic [CNT_W-1:0]     r_remaining;
    logic                 r_level;
    logic                 w_ready;
    logic                 w_clear;
    logic                 w_level_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_clear = 1'b0;
        unique case (r_state)
            SCAN: begin
                if (r_scan == CNT_W'(CELLS)) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                w_ready = 1'b1;
                if (tile_valid) begin
                    w_next = READ;
                end
            end
            READ: begin
                w_next = CHECK;
            end
            CHECK: begin
                w_next = out_b ? CLEAR : IDLE;
            end
            CLEAR: begin
                w_clear = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = SCAN;
            end
        endcase
    end

    assign w_scan_inc  = r_scan + CNT_W'(1);
    assign w_level_now = (r_state == IDLE) && (r_remaining == '0);

    // Store data lags the address by a cycle, so scan cycle 0 counts nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_remaining <= '0;
            r_level     <= 1'b0;
        end else begin
            if (r_state == SCAN) begin
                r_scan     <= w_scan_inc;
                {r_y, r_x} <= w_scan_inc[ADDR_W-1:0];
                if ((r_scan != '0) && out_b) begin
                    r_remaining <= r_remaining + CNT_W'(1);
                end
            end
            if ((r_state == IDLE) && tile_valid) begin
                r_x <= tile_x;
                r_y <= tile_y;
            end
            if ((r_state == CLEAR) && (r_remaining != '0)) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_level_now) begin
                r_level <= 1'b1;
            end
        end
    end

    score_counter #(
        .W(SCORE_W)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (w_clear),
        .amount(SCORE_W'(POINTS)),
        .value (score)
    );

    assign tile_ready  = w_ready & ~reset;
    assign clear_b     = w_clear & ~reset;
    assign eaten       = w_clear & ~reset;
    assign xpos_b      = r_x;
    assign ypos_b      = r_y;
    assign remaining   = r_remaining;
    assign level_clear = (r_level | w_level_now) & ~reset;

endmodule

// File: tb/tb_pellet_eater.sv
// Randomized bench for pellet_eater with a behavioural pellet store and
// a tile-level reference model of score, pellets left and level state.
module tb_pellet_eater;

    localparam int SW   = 10;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tile_valid = 1'b0;
    logic [4:0]    tile_x = '0;
    logic [4:0]    tile_y = '0;
    logic          tile_ready;
    logic [4:0]    xpos_b;
    logic [4:0]    ypos_b;
    logic          clear_b;
    logic          out_b;
    logic          eaten;
    logic [SW-1:0] score;
    logic [10:0]   remaining;
    logic          level_clear;

    logic map_bits [1024];
    logic mem [1024];

    bit ref_mem [1024];
    int ref_score;
    int ref_rem;
    bit ref_level;
    int pop;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pellet_eater #(
        .POINTS (10),
        .SCORE_W(SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tile_valid (tile_valid),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .tile_ready (tile_ready),
        .xpos_b     (xpos_b),
        .ypos_b     (ypos_b),
        .clear_b    (clear_b),
        .out_b      (out_b),
        .eaten      (eaten),
        .score      (score),
        .remaining  (remaining),
        .level_clear(level_clear)
    );

    // Pellet store: reloads the map on reset, one-cycle read latency.
    always @(posedge clk) begin
        if (reset) begin
            mem   <= map_bits;
            out_b <= 1'b0;
        end else if (clear_b) begin
            mem[{ypos_b, xpos_b}] <= 1'b0;
        end else begin
            out_b <= mem[{ypos_b, xpos_b}];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reload();
        for (int i = 0; i < 1024; i++) ref_mem[i] = map_bits[i];
        ref_score = 0;
        ref_rem   = 0;
        ref_level = 1'b0;
    endtask

    // Called in cycle 0 after reset release; valid is held to prove it is ignored.
    task automatic scan_check();
        int cnt;
        int bad_addr;
        cnt      = 0;
        bad_addr = 0;
        tile_valid = 1'b1;
        tile_x     = 5'd3;
        tile_y     = 5'd4;
        check("scan_addr0", int'({ypos_b, xpos_b}), 0);
        while (cnt < 1100 && !tile_ready) begin
            tick();
            cnt++;
            if (cnt < 1024 && int'({ypos_b, xpos_b}) != cnt) bad_addr++;
        end
        tile_valid = 1'b0;
        check("scan_len", cnt, 1025);
        check("scan_addr", bad_addr, 0);
        ref_rem = pop;
        if (pop == 0) ref_level = 1'b1;
        check("scan_remaining", int'(remaining), ref_rem);
        check("scan_score", int'(score), 0);
        check("scan_level", int'(level_clear), int'(ref_level));
        tick();
        check("scan_no_queue", int'(tile_ready), 1);
    endtask

    task automatic req(input int x, input int y);
        int a;
        int lat;
        int nclr;
        int neat;
        int badaddr;
        int w;
        bit hit;
        a = y * 32 + x;
        hit = ref_mem[a];
        w = 0;
        while (!tile_ready && w < 10) begin
            tick();
            w++;
        end
        if (!tile_ready) check("ready_timeout", 0, 1);
        tile_valid = 1'b1;
        tile_x     = 5'(x);
        tile_y     = 5'(y);
        tick();
        tile_valid = 1'b0;
        check("req_addr", int'({ypos_b, xpos_b}), a);
        lat = 0;
        nclr = 0;
        neat = 0;
        badaddr = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (clear_b) begin
                nclr++;
                if (int'({ypos_b, xpos_b}) != a) badaddr++;
            end
            if (eaten) neat++;
            if (tile_ready) lat = k;
            else tick();
        end
        if (hit) begin
            ref_mem[a] = 1'b0;
            ref_score  = (ref_score + 10 > SMAX) ? SMAX : ref_score + 10;
            ref_rem    = (ref_rem > 0) ? ref_rem - 1 : 0;
        end
        if (ref_rem == 0) ref_level = 1'b1;
        check("req_latency", lat, hit ? 4 : 3);
        check("req_clear", nclr, int'(hit));
        check("req_eaten", neat, int'(hit));
        check("req_clr_addr", badaddr, 0);
        check("req_score", int'(score), ref_score);
        check("req_remaining", int'(remaining), ref_rem);
        check("req_level", int'(level_clear), int'(ref_level));
    endtask

    initial begin
        int sx;
        int sy;
        int nclr;

        pop = 0;
        for (int i = 0; i < 1024; i++) begin
            map_bits[i] = 1'($urandom_range(0, 1));
        end
        map_bits[0]      = 1'b0;
        map_bits[2*32+2] = 1'b1;
        for (int i = 0; i < 1024; i++) pop += int'(map_bits[i]);
        model_reload();

        reset = 1'b1;
        repeat (3) tick();
        check("rst_xy", int'({ypos_b, xpos_b}), 0);
        check("rst_ready", int'(tile_ready), 0);
        check("rst_clear", int'(clear_b), 0);
        check("rst_eaten", int'(eaten), 0);
        check("rst_score", int'(score), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_level", int'(level_clear), 0);
        reset = 1'b0;
        scan_check();

        req(2, 2);
        req(0, 0);
        req(2, 2);
        for (int i = 0; i < 40; i++) begin
            req(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end

        sx = 2;
        sy = 2;
        for (int i = 0; i < 1024; i++) begin
            if (ref_mem[i]) begin
                sx = i % 32;
                sy = i / 32;
            end
        end
        tile_valid = 1'b1;
        tile_x     = 5'(sx);
        tile_y     = 5'(sy);
        tick();
        tile_valid = 1'b0;
        nclr = int'(clear_b);
        tick();
        nclr += int'(clear_b);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            nclr += int'(clear_b);
        end
        check("abort_clear", nclr, 0);
        check("abort_score", int'(score), 0);
        check("abort_remaining", int'(remaining), 0);
        check("abort_ready", int'(tile_ready), 0);
        model_reload();
        reset = 1'b0;
        scan_check();

        for (int i = 0; i < 1024; i++) req(i % 32, i / 32);
        check("final_remaining", int'(remaining), 0);
        check("final_score", int'(score), SMAX);
        check("final_level", int'(level_clear), 1);
        req(2, 2);
        req(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pellet_eater.md
PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001 Parameter POINTS, default 10, score added per pellet eaten.
REQ-002 Parameter SCORE_W, default 16, width of score output.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 tile_valid  input  1  player has entered a new tile; request to eat at tile_x/tile_y.
REQ-006 tile_x  input  5  requested tile column.
REQ-007 tile_y  input  5  requested tile row.
REQ-008 tile_ready  output  1  request accepted when tile_valid and tile_ready are both high on the same edge.
REQ-009 xpos_b  output  5  pellet-store port-B column, registered.
REQ-010 ypos_b  output  5  pellet-store port-B row, registered.
REQ-011 clear_b  output  1  pellet-store port-B clear strobe.
REQ-012 out_b  input  1  pellet-store port-B read data; valid one cycle after address is presented with clear_b low.
REQ-013 eaten  output  1  one-cycle pulse when a pellet is consumed.
REQ-014 score  output  SCORE_W  accumulated score.
REQ-015 remaining  output  11  pellets left in the maze.
REQ-016 level_clear  output  1  sticky; all pellets eaten.

Function
REQ-017 FSM states SHALL be SCAN, IDLE, READ, CHECK, CLEAR.
REQ-018 SCAN: cycle n after reset release (n=0..1023) presents address n (ypos_b=n[9:5], xpos_b=n[4:0]) with clear_b low; out_b sampled in cycles 1..1024 is counted into remaining.
REQ-019 SCAN SHALL last exactly 1025 cycles, then enter IDLE; tile_ready SHALL be low throughout, and tile_valid is ignored (not queued).
REQ-020 tile_ready SHALL be high only in IDLE.
REQ-021 Accept in IDLE (cycle T): latch tile_x/tile_y, go to READ; xpos_b/ypos_b show latched tile in T+1.
REQ-022 READ (T+1): clear_b low; go to CHECK.
REQ-023 CHECK (T+2): out_b=1 -> CLEAR; out_b=0 -> IDLE, with no score change and no eaten pulse.
REQ-024 CLEAR (T+3): clear_b high for exactly one cycle at the latched address; eaten=1; score += POINTS; remaining -= 1; go to IDLE.
REQ-025 Request-to-ready latency SHALL be 3 cycles (miss) or 4 cycles (hit).
REQ-026 score SHALL saturate at 2^SCORE_W-1, never wrap.
REQ-027 remaining SHALL never decrement below 0; a hit with remaining=0 still clears and scores.
REQ-028 level_clear SHALL set on the first cycle in IDLE with remaining=0 (including an empty map after SCAN) and hold until reset.
REQ-029 A repeated request for an already-cleared tile SHALL be a miss.
REQ-030 Requests continue to be served after level_clear.

Reset
REQ-031 While reset is high: state=SCAN with scan address 0; xpos_b=0, ypos_b=0, clear_b=0, tile_ready=0, eaten=0, score=0, remaining=0, level_clear=0.
REQ-032 Reset mid-operation SHALL abort any request without asserting clear_b, then restart SCAN; the pellet store reloads on the same reset.

Structure
REQ-033 The shared package pellet_pkg SHALL hold GRID_BITS=5, CELLS=1024, the FSM state enum, and default POINTS.
REQ-034 Saturating score accumulator SHALL be sub-module score_counter (inc, amount, reset, value).
REQ-035 The block SHALL have no memory of its own; all pellet state lives in the pellet store.

Verification
REQ-036 Reset with default map -> tile_ready rises exactly 1025 cycles after release; remaining equals the bench popcount of the map; score=0.
REQ-037 Request (x=2,y=2) (pellet present) -> clear_b high at T+3 at (2,2); eaten pulse; score=10; remaining decremented by 1; tile_ready high at T+4.
REQ-038 Request (x=0,y=0) (empty) -> no clear_b, no eaten, score unchanged, tile_ready high at T+3.
REQ-039 Request (2,2) twice -> second request is a miss; score stays 10.
REQ-040 Preload score=65530 via forced state, two hits -> score=65535.
REQ-041 Assert reset at T+2 of a hit -> clear_b never asserted, score=0, SCAN restarts; bench then eats every pellet -> level_clear rises with remaining=0.
